// File: rtl/rate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rate_scheduler
// Purpose  : Programmable period tick generator. A selected reload value is
//            latched on LOAD, a down-counter emits a one-cycle tick every
//            curRate+1 cycles, and a small wrapping counter tracks the ticks.
// Revision : 1.0 - initial release
// ============================================================================
module rate_scheduler #(
    parameter int RATE_WIDTH  = 20,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             MuxSelect,
    input  logic [RATE_WIDTH-1:0]  rateFull,
    input  logic [RATE_WIDTH-1:0]  rateOne,
    input  logic [RATE_WIDTH-1:0]  rateHalf,
    input  logic [RATE_WIDTH-1:0]  rateQuarter,
    output logic                   tick,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [RATE_WIDTH-1:0]  curRate,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [RATE_WIDTH-1:0]   r_counter;
    logic [RATE_WIDTH-1:0]   r_curRate;
    logic [1:0]              r_selLatched;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_tick;
    logic [RATE_WIDTH-1:0]   w_selRate;
    logic                    w_running;

    // Candidate reload value picked by the current rate select.
    always_comb begin
        w_selRate = rateFull;
        case (MuxSelect)
            2'b00:   w_selRate = rateFull;
            2'b01:   w_selRate = rateOne;
            2'b10:   w_selRate = rateHalf;
            default: w_selRate = rateQuarter;
        endcase
    end

    // Counting proceeds only when still enabled and the rate select is stable;
    // a select change takes priority and forces a reload without a tick.
    assign w_running = enable && (MuxSelect == r_selLatched);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state decode.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_stateNext = LOAD;
                end
            end
            LOAD: begin
                w_stateNext = COUNT;
            end
            COUNT: begin
                if (!enable) begin
                    w_stateNext = IDLE;
                end else if (MuxSelect != r_selLatched) begin
                    w_stateNext = LOAD;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: reload on LOAD, count down in COUNT, tick and reload at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_counter    <= '0;
            r_curRate    <= '0;
            r_selLatched <= 2'b00;
            r_count      <= '0;
            r_tick       <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_counter    <= w_selRate;
                    r_curRate    <= w_selRate;
                    r_selLatched <= MuxSelect;
                end
                COUNT: begin
                    if (w_running) begin
                        if (r_counter != '0) begin
                            r_counter <= r_counter - RATE_WIDTH'(1);
                        end else begin
                            r_counter <= r_curRate;
                            r_tick    <= 1'b1;
                            r_count   <= r_count + COUNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tick    = r_tick;
    assign count   = r_count;
    assign curRate = r_curRate;
    assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/rate_scheduler.md
RATE_SCHEDULER -- requirements
Module: rate_scheduler

Interface
REQ-001 Parameter RATE_WIDTH, default 20: width of every rate value, counter and curRate.
REQ-002 Parameter COUNT_WIDTH, default 4: width of the display count.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clock only.
REQ-004 clock  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  run request; 1 = schedule ticks, 0 = pause.
REQ-007 MuxSelect  input  2  rate select: 00 rateFull, 01 rateOne, 10 rateHalf, 11 rateQuarter.
REQ-008 rateFull, rateOne, rateHalf, rateQuarter  input  RATE_WIDTH each  candidate reload values.
REQ-009 tick  output  1  registered one-cycle pulse at end of each period.
REQ-010 count  output  COUNT_WIDTH  registered tick counter, drives display.
REQ-011 curRate  output  RATE_WIDTH  registered rate latched at last LOAD.
REQ-012 busy  output  1  high while state is LOAD or COUNT.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, LOAD, COUNT.
REQ-014 IDLE: enable=1 -> LOAD; else stay; counter, count, curRate held; tick=0.
REQ-015 LOAD: unconditionally -> COUNT after one cycle; latches the selected rate into counter and curRate, and latches MuxSelect into an internal selLatched register; tick=0.
REQ-016 COUNT, priority 1: enable=0 -> IDLE; counter and count held; tick=0.
REQ-017 COUNT, priority 2: MuxSelect != selLatched -> LOAD; no tick, no count increment, even if counter=0 that cycle.
REQ-018 COUNT, priority 3: counter != 0 -> counter decrements by 1; tick=0.
REQ-019 COUNT, priority 3: counter = 0 -> counter reloads from curRate; tick=1 for the following cycle only; count increments by 1.
REQ-020 count SHALL wrap from all-ones to 0 without any other side effect.
REQ-021 Steady-state tick period SHALL be curRate+1 cycles; curRate=0 SHALL give tick high on every cycle in COUNT.
REQ-022 First tick latency: enable sampled 1 at edge E0 (in IDLE) -> LOAD; counter=R after E1; tick high after edge E(R+2).
REQ-023 Changes on rate inputs SHALL not affect curRate or period until the next LOAD.
REQ-024 Re-enabling from IDLE SHALL always pass through LOAD; the partial period SHALL restart and count SHALL be preserved.
REQ-025 tick SHALL never be high for two consecutive cycles unless curRate=0.
REQ-026 busy SHALL be decoded from the state register only, with no combinational path from inputs.
REQ-027 Counter arithmetic SHALL be unsigned RATE_WIDTH; counter SHALL never underflow.

Reset
REQ-028 reset=1 at an edge SHALL force the following, overriding every other condition including mid-period: state IDLE, counter 0, curRate 0, selLatched 00, count 0, tick 0, busy 0.
REQ-029 reset asserted in the same cycle as enable=1 SHALL leave the block in IDLE; LOAD is entered only on a later edge with reset=0 and enable=1.

Verification
REQ-030 Reset, then enable=1, MuxSelect=01, rateOne=3 -> busy=1 after E0; curRate=3 after E1; tick after E5, E9, E13; count=1, 2, 3.
REQ-031 MuxSelect=00, rateFull=0, enable held 20 cycles after LOAD -> tick high every COUNT cycle; count wraps F->0 after 16 ticks.
REQ-032 rateOne=3, switch MuxSelect to 10 (rateHalf=5) on the cycle counter=0 -> no tick that cycle; LOAD; curRate=5; next tick 7 cycles later; count unchanged by the switch.
REQ-033 Drop enable mid-period with count=2 -> IDLE next edge, tick=0, count stays 2; re-enable -> LOAD, full R+1 period before the next tick.
REQ-034 Assert reset mid-period with count=5 and tick pending -> tick=0, count=0, curRate=0, busy=0 after the edge; no tick emitted.
REQ-035 Change rateOne from 3 to 9 while in COUNT with MuxSelect unchanged -> period stays 4 cycles until enable is toggled; then it becomes 10 cycles.
